instr_decode_queue: RTL and testbench

INSTR_DECODE_QUEUE -- requirements
Module: instr_decode_queue

---
 rtl/instr_decode_queue_pkg.sv | 31 +++
 rtl/instr_decode_queue_if.sv | 32 +++
 rtl/instr_decode_queue_decoder.sv | 38 +++
 rtl/instr_decode_queue.sv | 125 ++++++++++++
 tb/tb_instr_decode_queue.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_decode_queue_pkg.sv
// Shared types and constants for the instruction decode queue: raw instruction
// width, opcode values, MAC operation encodings and the decoded entry layout.
package instr_decode_queue_pkg;

    localparam int INSTR_SIZE = 52;

    localparam logic [3:0] OP_NOP        = 4'h0;
    localparam logic [3:0] OP_MATMUL     = 4'h1;
    localparam logic [3:0] OP_MATMUL_ACC = 4'h2;

    localparam logic [2:0] MAC_OP_MATMUL     = 3'b010;
    localparam logic [2:0] MAC_OP_MATMUL_ACC = 3'b011;

    typedef struct packed {
        logic [2:0]  MAC_op;
        logic [7:0]  V_dim;
        logic [7:0]  U_dim;
        logic [7:0]  ITER_dim;
        logic [7:0]  V_dim1;
        logic [7:0]  U_dim1;
        logic [7:0]  ITER_dim1;
        logic [11:0] unified_buffer_start_addr_rd;
        logic [11:0] unified_buffer_start_addr_wr;
    } decoded_instr_t;

    // Loop bounds downstream are programmed as "dimension minus one"; 0 wraps to 8'hFF.
    function automatic logic [7:0] dim_minus_one(input logic [7:0] dim);
        return dim - 8'd1;
    endfunction

endpackage

// File: rtl/instr_decode_queue_if.sv
// Producer/consumer bus of the instruction decode queue; master is the
// environment driving instructions and taking decoded entries, slave is the queue.
interface instr_decode_queue_if #(
    parameter int DEPTH = 32
);
    import instr_decode_queue_pkg::*;

    logic                    flush_i;
    logic [INSTR_SIZE-1:0]   instr_i;
    logic                    wr_valid_i;
    logic                    wr_ready_o;
    logic                    rd_valid_o;
    logic                    rd_ready_i;
    decoded_instr_t          decoded_instr_o;
    logic [$clog2(DEPTH):0]  count_o;
    logic                    almost_full_o;
    logic                    almost_empty_o;
    logic                    illegal_o;

    modport master (
        output flush_i, instr_i, wr_valid_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, decoded_instr_o, count_o,
               almost_full_o, almost_empty_o, illegal_o
    );

    modport slave (
        input  flush_i, instr_i, wr_valid_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, decoded_instr_o, count_o,
               almost_full_o, almost_empty_o, illegal_o
    );

endinterface

// File: rtl/instr_decode_queue_decoder.sv
// Combinational instruction decoder: classifies the opcode and unpacks the
// MATMUL fields into a decoded entry.
module instr_decoder
    import instr_decode_queue_pkg::*;
(
    input  logic [INSTR_SIZE-1:0] instr,
    output decoded_instr_t        decoded,
    output logic                  enq,
    output logic                  illegal
);

    always_comb begin
        decoded = '0;
        enq     = 1'b0;
        illegal = 1'b0;
        case (instr[3:0])
            OP_NOP: begin
                enq = 1'b0;
            end
            OP_MATMUL, OP_MATMUL_ACC: begin
                enq = 1'b1;
                decoded.MAC_op = (instr[3:0] == OP_MATMUL_ACC) ? MAC_OP_MATMUL_ACC : MAC_OP_MATMUL;
                decoded.V_dim     = instr[11:4];
                decoded.U_dim     = instr[19:12];
                decoded.ITER_dim  = instr[27:20];
                decoded.V_dim1    = dim_minus_one(instr[11:4]);
                decoded.U_dim1    = dim_minus_one(instr[19:12]);
                decoded.ITER_dim1 = dim_minus_one(instr[27:20]);
                decoded.unified_buffer_start_addr_rd = instr[39:28];
                decoded.unified_buffer_start_addr_wr = instr[51:40];
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_queue.sv
// Decoding instruction queue: decodes accepted instructions and holds the
// enqueueable ones in a show-ahead circular buffer with occupancy flags.
module instr_decode_queue #(
    parameter int DEPTH = 32,
    parameter int AF_TH = DEPTH - 2,
    parameter int AE_TH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    instr_decode_queue_if.slave   bus
);
    import instr_decode_queue_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_TH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_TH);

    typedef enum logic [1:0] {RESET, EMPTY, STEADY, FULL} state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            almost_full;
    logic            almost_empty;
    logic            illegal_q;
    decoded_instr_t  storage [DEPTH];

    decoded_instr_t  dec;
    logic            dec_enq;
    logic            dec_illegal;
    logic            wr_ready;
    logic            rd_valid;
    logic            push;
    logic            pop;
    logic            enq_push;

    instr_decoder u_decoder (
        .instr   (bus.instr_i),
        .decoded (dec),
        .enq     (dec_enq),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= RESET;
        else       state <= state_next;
    end

    always_comb begin
        rd_valid   = (state == STEADY) || (state == FULL);
        wr_ready   = !rst_i && ((state == EMPTY) || (state == STEADY));
        push       = bus.wr_valid_i && wr_ready;
        pop        = rd_valid && bus.rd_ready_i && !bus.flush_i;
        enq_push   = push && dec_enq && !bus.flush_i;
        state_next = state;
        count_next = count;

        if (bus.flush_i) begin
            count_next = '0;
        end else if (enq_push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !enq_push) begin
            count_next = count - CNT_ONE;
        end

        // Flush overrides every transition, including leaving RESET.
        if (bus.flush_i) begin
            state_next = EMPTY;
        end else begin
            case (state)
                RESET:  state_next = EMPTY;
                EMPTY:  if (enq_push) state_next = STEADY;
                STEADY: begin
                    if (enq_push && !pop && count == CNT_LAST)    state_next = FULL;
                    else if (pop && !enq_push && count == CNT_ONE) state_next = EMPTY;
                end
                FULL:   if (pop) state_next = STEADY;
                default: state_next = RESET;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            illegal_q    <= 1'b0;
        end else begin
            count        <= count_next;
            almost_full  <= (count_next >= AF_LVL);
            almost_empty <= (count_next <= AE_LVL);
            illegal_q    <= push && dec_illegal && !bus.flush_i;
            if (bus.flush_i) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (enq_push) wr_ptr <= wr_ptr + PTR_ONE;
                if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_push) storage[wr_ptr] <= dec;
    end

    assign bus.wr_ready_o      = wr_ready;
    assign bus.rd_valid_o      = rd_valid;
    assign bus.decoded_instr_o = storage[rd_ptr];
    assign bus.count_o         = count;
    assign bus.almost_full_o   = almost_full;
    assign bus.almost_empty_o  = almost_empty;
    assign bus.illegal_o       = illegal_q;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: table-driven vectors on a DEPTH=4 queue with a
// data scoreboard, plus reset and pointer-wrap sequences on a DEPTH=32 queue.
module tb_instr_decode_queue;
    import instr_decode_queue_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4  = 1'b1;
    logic rst32 = 1'b1;

    instr_decode_queue_if #(.DEPTH(4))  bus4 ();
    instr_decode_queue_if #(.DEPTH(32)) bus32 ();

    instr_decode_queue #(.DEPTH(4), .AF_TH(2), .AE_TH(2)) dut4 (
        .clk_i (clk),
        .rst_i (rst4),
        .bus   (bus4)
    );

    instr_decode_queue #(.DEPTH(32)) dut32 (
        .clk_i (clk),
        .rst_i (rst32),
        .bus   (bus32)
    );

    typedef struct {
        logic        fl;
        logic        wv;
        logic [51:0] ins;
        logic        rr;
        int          cnt;
        logic        ill;
        logic        rv;
        logic        wr;
        logic        af;
        logic        ae;
    } vec_t;

    int checks = 0;
    int errors = 0;
    decoded_instr_t sb4[$];
    decoded_instr_t sb32[$];
    vec_t tbl[$];
    logic prev_rv = 1'b0;
    logic prev_wr = 1'b0;

    function automatic logic [51:0] mk(input logic [3:0] op, input logic [7:0] v, input logic [7:0] u,
                                       input logic [7:0] it, input logic [11:0] rd, input logic [11:0] wr);
        return {wr, rd, it, u, v, op};
    endfunction

    function automatic logic [51:0] tag(input int n);
        return mk(4'h1, 8'(n), 8'(n + 1), 8'(n + 2), 12'(n * 16), 12'(n * 32));
    endfunction

    function automatic decoded_instr_t expect_dec(input logic [51:0] ins);
        decoded_instr_t d;
        d.MAC_op    = (ins[3:0] == 4'h2) ? 3'b011 : 3'b010;
        d.V_dim     = ins[11:4];
        d.U_dim     = ins[19:12];
        d.ITER_dim  = ins[27:20];
        d.V_dim1    = ins[11:4] - 8'd1;
        d.U_dim1    = ins[19:12] - 8'd1;
        d.ITER_dim1 = ins[27:20] - 8'd1;
        d.unified_buffer_start_addr_rd = ins[39:28];
        d.unified_buffer_start_addr_wr = ins[51:40];
        return d;
    endfunction

    function automatic vec_t mkv(input logic fl, input logic wv, input logic [51:0] ins, input logic rr,
                                 input int cnt, input logic ill, input logic rv, input logic wr,
                                 input logic af, input logic ae);
        vec_t v;
        v.fl = fl; v.wv = wv; v.ins = ins; v.rr = rr; v.cnt = cnt;
        v.ill = ill; v.rv = rv; v.wr = wr; v.af = af; v.ae = ae;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One DEPTH=4 cycle: drive, score pops/pushes, clock, then check the flags.
    task automatic apply4(input vec_t v);
        decoded_instr_t e;
        bus4.flush_i    = v.fl;
        bus4.wr_valid_i = v.wv;
        bus4.instr_i    = v.ins;
        bus4.rd_ready_i = v.rr;
        if (v.rr && prev_rv && !v.fl) begin
            if (sb4.size() == 0) begin
                chk("sb4_underflow", 1, 0);
            end else begin
                e = sb4.pop_front();
                chk("head_data", bus4.decoded_instr_o, e);
            end
        end
        if (v.fl) sb4.delete();
        else if (v.wv && prev_wr && (v.ins[3:0] == 4'h1 || v.ins[3:0] == 4'h2))
            sb4.push_back(expect_dec(v.ins));
        @(posedge clk); #1;
        chk("count", bus4.count_o, v.cnt);
        chk("illegal", bus4.illegal_o, v.ill);
        chk("rd_valid", bus4.rd_valid_o, v.rv);
        chk("wr_ready", bus4.wr_ready_o, v.wr);
        chk("almost_full", bus4.almost_full_o, v.af);
        chk("almost_empty", bus4.almost_empty_o, v.ae);
        prev_rv = v.rv;
        prev_wr = v.wr;
    endtask

    task automatic reset4(input logic [51:0] ins);
        rst4 = 1'b1;
        bus4.flush_i    = 1'b0;
        bus4.wr_valid_i = 1'b1;
        bus4.instr_i    = ins;
        bus4.rd_ready_i = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", bus4.count_o, 0);
        chk("rst_rd_valid", bus4.rd_valid_o, 0);
        chk("rst_wr_ready", bus4.wr_ready_o, 0);
        chk("rst_almost_full", bus4.almost_full_o, 0);
        chk("rst_almost_empty", bus4.almost_empty_o, 1);
        chk("rst_illegal", bus4.illegal_o, 0);
        rst4 = 1'b0;
        bus4.wr_valid_i = 1'b0;
        bus4.rd_ready_i = 1'b0;
        #1;
        chk("reset_state_wr_ready", bus4.wr_ready_o, 0);
        @(posedge clk); #1;
        chk("empty_wr_ready", bus4.wr_ready_o, 1);
        chk("empty_rd_valid", bus4.rd_valid_o, 0);
        sb4.delete();
        prev_rv = 1'b0;
        prev_wr = 1'b1;
    endtask

    initial begin
        int sent;
        int got;
        int mcount;
        logic wv;
        logic rr;
        logic acc;
        logic pp;
        decoded_instr_t e;

        bus4.flush_i = 1'b0;  bus4.wr_valid_i = 1'b0;  bus4.instr_i = '0;  bus4.rd_ready_i = 1'b0;
        bus32.flush_i = 1'b0; bus32.wr_valid_i = 1'b0; bus32.instr_i = '0; bus32.rd_ready_i = 1'b0;

        //            fl  wv  instr                          rr cnt ill rv wr af ae
        tbl.push_back(mkv(0, 0, '0,                            1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 1, mk(4'h0, 1, 2, 3, 4, 5),       0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 1, mk(4'h7, 1, 2, 3, 4, 5),       0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 1, mk(4'h2, 5, 6, 7, 12'h123, 12'h456), 0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mkv(0, 0, '0,                            1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 1, tag(1),                        0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mkv(0, 1, tag(2),                        0, 2, 0, 1, 1, 1, 1));
        tbl.push_back(mkv(0, 1, tag(3),                        0, 3, 0, 1, 1, 1, 0));
        tbl.push_back(mkv(0, 1, tag(4),                        0, 4, 0, 1, 0, 1, 0));
        tbl.push_back(mkv(0, 1, tag(5),                        0, 4, 0, 1, 0, 1, 0));
        tbl.push_back(mkv(0, 1, tag(6),                        1, 3, 0, 1, 1, 1, 0));
        tbl.push_back(mkv(0, 1, tag(7),                        1, 3, 0, 1, 1, 1, 0));
        tbl.push_back(mkv(1, 1, mk(4'h7, 1, 2, 3, 4, 5),       1, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 0, '0,                            0, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mkv(0, 1, tag(9),                        0, 1, 0, 1, 1, 0, 1));
        tbl.push_back(mkv(0, 0, '0,                            1, 0, 0, 0, 1, 0, 1));

        reset4(mk(4'h0, 0, 0, 0, 0, 0));

        // First MATMUL is visible on the head one edge after the push.
        apply4(mkv(0, 1, mk(4'h1, 8, 4, 3, 12'h010, 12'h200), 0, 1, 0, 1, 1, 0, 1));
        chk("mm_mac_op", bus4.decoded_instr_o.MAC_op, 3'b010);
        chk("mm_v_dim1", bus4.decoded_instr_o.V_dim1, 8'd7);
        chk("mm_u_dim1", bus4.decoded_instr_o.U_dim1, 8'd3);
        chk("mm_iter_dim1", bus4.decoded_instr_o.ITER_dim1, 8'd2);
        chk("mm_addr_rd", bus4.decoded_instr_o.unified_buffer_start_addr_rd, 12'h010);
        chk("mm_addr_wr", bus4.decoded_instr_o.unified_buffer_start_addr_wr, 12'h200);

        for (int i = 0; i < tbl.size(); i++) apply4(tbl[i]);

        // Zero dimension wraps to 8'hFF.
        apply4(mkv(0, 1, mk(4'h1, 0, 0, 0, 0, 0), 0, 1, 0, 1, 1, 0, 1));
        chk("zero_dim_wrap", bus4.decoded_instr_o.V_dim1, 8'hFF);
        apply4(mkv(0, 0, '0, 1, 0, 0, 0, 1, 0, 1));

        // Reset in the middle of operation discards queued entries.
        apply4(mkv(0, 1, tag(10), 0, 1, 0, 1, 1, 0, 1));
        apply4(mkv(0, 1, tag(11), 0, 2, 0, 1, 1, 1, 1));
        apply4(mkv(0, 1, tag(12), 0, 3, 0, 1, 1, 1, 0));
        reset4(mk(4'h7, 0, 0, 0, 0, 0));
        apply4(mkv(0, 1, tag(13), 0, 1, 0, 1, 1, 0, 1));
        apply4(mkv(0, 0, '0,      1, 0, 0, 0, 1, 0, 1));

        // DEPTH=32: 40 tagged instructions through the pointer wrap under random back-pressure.
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wrap_init_wr_ready", bus32.wr_ready_o, 1);
        sent = 0; got = 0; mcount = 0;
        for (int cyc = 0; cyc < 600 && got < 40; cyc++) begin
            wv = (sent < 40);
            rr = 1'($urandom_range(0, 1));
            bus32.wr_valid_i = wv;
            bus32.instr_i    = tag(sent + 100);
            bus32.rd_ready_i = rr;
            acc = wv && (mcount < 32);
            pp  = rr && (mcount > 0);
            if (pp) begin
                e = sb32.pop_front();
                chk("wrap_data", bus32.decoded_instr_o, e);
                got++;
            end
            if (acc) begin
                sb32.push_back(expect_dec(tag(sent + 100)));
                sent++;
            end
            mcount = mcount + (acc ? 1 : 0) - (pp ? 1 : 0);
            @(posedge clk); #1;
            chk("wrap_count", bus32.count_o, mcount);
        end
        bus32.wr_valid_i = 1'b0;
        bus32.rd_ready_i = 1'b0;
        chk("wrap_received", got, 40);
        chk("wrap_sb_empty", sb32.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
